// File: rtl/hazard_pkg.sv
// Shared hazard-control types: result classes, forward selects, Tnew table.
// MDU latencies are used only when HAZ_MDU_EN is defined.
package hazard_pkg;

   typedef enum logic [2:0] {
      RES_NW  = 3'd0,
      RES_ALU = 3'd1,
      RES_DM  = 3'd2,
      RES_PC  = 3'd3,
      RES_MD  = 3'd4
   } res_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_E  = 2'd1,
      FWD_M  = 2'd2,
      FWD_W  = 2'd3
   } fwd_t;

   typedef enum logic [1:0] {
      STG_E = 2'd0,
      STG_M = 2'd1,
      STG_W = 2'd2
   } stg_t;

   localparam logic [3:0] MD_LAT_MUL = 4'd5;
   localparam logic [3:0] MD_LAT_DIV = 4'd10;

   // Codes 5-7 carry no writeback.
   function automatic res_t res_decode(input logic [2:0] r);
      res_t c;
      case (r)
         3'd1:    c = RES_ALU;
         3'd2:    c = RES_DM;
         3'd3:    c = RES_PC;
         3'd4:    c = RES_MD;
         default: c = RES_NW;
      endcase
      return c;
   endfunction

   function automatic logic [1:0] tnew(input stg_t s, input res_t r);
      logic [1:0] t;
      t = 2'd0;
      case (s)
         STG_E: begin
            case (r)
               RES_ALU, RES_MD: t = 2'd1;
               RES_DM:          t = 2'd2;
               default:         t = 2'd0;
            endcase
         end
         STG_M: begin
            if (r == RES_DM)
               t = 2'd1;
         end
         default: t = 2'd0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Nearest-stage forward select for one operand; a stage is
// disabled by presenting RES_NW as its class.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] wa_e,
   input  res_t       res_e,
   input  logic [4:0] wa_m,
   input  res_t       res_m,
   input  logic [4:0] wa_w,
   input  res_t       res_w,
   output fwd_t       sel
);

   logic hit_e;
   logic hit_m;
   logic hit_w;
   logic rdy_e;
   logic rdy_m;

   assign hit_e = (res_e != RES_NW) && (wa_e == src);
   assign hit_m = (res_m != RES_NW) && (wa_m == src);
   assign hit_w = (res_w != RES_NW) && (wa_w == src);
   assign rdy_e = (tnew(STG_E, res_e) == 2'd0);
   assign rdy_m = (tnew(STG_M, res_m) == 2'd0);

   // A not-ready nearest match blocks older stages.
   always_comb begin
      sel = FWD_RF;
      if (src == 5'd0)
         sel = FWD_RF;
      else if (hit_e)
         sel = rdy_e ? FWD_E : FWD_RF;
      else if (hit_m)
         sel = rdy_m ? FWD_M : FWD_RF;
      else if (hit_w)
         sel = FWD_W;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forward control for the 5-stage pipeline.
// Define HAZ_MDU_EN to add the mult/div busy counter and its stall.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ra1D,
   input  logic [4:0] ra2D,
   input  logic [1:0] tuse1D,
   input  logic [1:0] tuse2D,
   input  logic [4:0] ra1E,
   input  logic [4:0] ra2E,
   input  logic [4:0] waE,
   input  logic [2:0] resE,
   input  logic [4:0] ra1M,
   input  logic [4:0] ra2M,
   input  logic [4:0] waM,
   input  logic [2:0] resM,
   input  logic [4:0] waW,
   input  logic [2:0] resW,
   input  logic [1:0] md_startE,
   input  logic       md_useD,
   output logic       stall,
   output logic [1:0] fwd_rs_D,
   output logic [1:0] fwd_rt_D,
   output logic [1:0] fwd_rs_E,
   output logic [1:0] fwd_rt_E,
   output logic       fwd_rt_M,
   output logic       md_busy
);

   res_t cls_e;
   res_t cls_m;
   res_t cls_w;
   logic [1:0] tn_e;
   logic [1:0] tn_m;
   logic stall_rs;
   logic stall_rt;
   logic data_stall;
   fwd_t sel_rs_d;
   fwd_t sel_rt_d;
   fwd_t sel_rs_e;
   fwd_t sel_rt_e;
   fwd_t sel_rt_m;

   assign cls_e = res_decode(resE);
   assign cls_m = res_decode(resM);
   assign cls_w = res_decode(resW);
   assign tn_e  = tnew(STG_E, cls_e);
   assign tn_m  = tnew(STG_M, cls_m);

   // Unused operands (tuse=3) never stall since Tnew tops out at 2.
   always_comb begin
      stall_rs = 1'b0;
      stall_rt = 1'b0;
      if (ra1D != 5'd0) begin
         if (cls_e != RES_NW && waE == ra1D && tn_e > tuse1D)
            stall_rs = 1'b1;
         if (cls_m != RES_NW && waM == ra1D && tn_m > tuse1D)
            stall_rs = 1'b1;
      end
      if (ra2D != 5'd0) begin
         if (cls_e != RES_NW && waE == ra2D && tn_e > tuse2D)
            stall_rt = 1'b1;
         if (cls_m != RES_NW && waM == ra2D && tn_m > tuse2D)
            stall_rt = 1'b1;
      end
   end

   assign data_stall = stall_rs | stall_rt;

   fwd_sel u_rs_d (
      .src(ra1D), .wa_e(waE), .res_e(cls_e),
      .wa_m(waM), .res_m(cls_m),
      .wa_w(waW), .res_w(cls_w), .sel(sel_rs_d)
   );

   fwd_sel u_rt_d (
      .src(ra2D), .wa_e(waE), .res_e(cls_e),
      .wa_m(waM), .res_m(cls_m),
      .wa_w(waW), .res_w(cls_w), .sel(sel_rt_d)
   );

   fwd_sel u_rs_e (
      .src(ra1E), .wa_e(5'd0), .res_e(RES_NW),
      .wa_m(waM), .res_m(cls_m),
      .wa_w(waW), .res_w(cls_w), .sel(sel_rs_e)
   );

   fwd_sel u_rt_e (
      .src(ra2E), .wa_e(5'd0), .res_e(RES_NW),
      .wa_m(waM), .res_m(cls_m),
      .wa_w(waW), .res_w(cls_w), .sel(sel_rt_e)
   );

   fwd_sel u_rt_m (
      .src(ra2M), .wa_e(5'd0), .res_e(RES_NW),
      .wa_m(5'd0), .res_m(RES_NW),
      .wa_w(waW), .res_w(cls_w), .sel(sel_rt_m)
   );

   assign fwd_rs_D = sel_rs_d;
   assign fwd_rt_D = sel_rt_d;
   assign fwd_rs_E = sel_rs_e;
   assign fwd_rt_E = sel_rt_e;
   assign fwd_rt_M = (sel_rt_m == FWD_W);

   logic unused_ra1m;
   assign unused_ra1m = ^ra1M;

`ifdef HAZ_MDU_EN
   logic [3:0] cnt;
   logic start_mul;
   logic start_div;
   logic md_stall;

   assign start_mul = (md_startE == 2'd1);
   assign start_div = (md_startE == 2'd2);

   // A new start reloads even while busy.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= 4'd0;
      else if (start_mul)
         cnt <= MD_LAT_MUL;
      else if (start_div)
         cnt <= MD_LAT_DIV;
      else if (cnt != 4'd0)
         cnt <= cnt - 4'd1;
   end

   assign md_busy  = (cnt != 4'd0);
   assign md_stall = md_useD & (md_busy | start_mul | start_div);
   assign stall    = data_stall | md_stall;
`else
   logic unused_md;
   assign unused_md = ^{clk, rst, md_startE, md_useD};
   assign md_busy   = 1'b0;
   assign stall     = data_stall;
`endif

endmodule
